// File: rtl/chacha_pkg.sv
// Shared types, constants and index tables for the ChaCha block generator.
package chacha_pkg;

   localparam logic [127:0] CHACHA_CONST_DEFAULT = 128'h41523235_4C454F4D_43544B59_494D5041;

   typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL, ST_HOLD} state_e;

   typedef logic [15:0][31:0] state_t;

   // Column and diagonal quarter-round operand sets, ordered (a, b, c, d).
   localparam logic [3:0] COL_IDX [4][4] = '{
      '{4'd0, 4'd4, 4'd8,  4'd12},
      '{4'd1, 4'd5, 4'd9,  4'd13},
      '{4'd2, 4'd6, 4'd10, 4'd14},
      '{4'd3, 4'd7, 4'd11, 4'd15}
   };
   localparam logic [3:0] DIAG_IDX [4][4] = '{
      '{4'd0, 4'd5, 4'd10, 4'd15},
      '{4'd1, 4'd6, 4'd11, 4'd12},
      '{4'd2, 4'd7, 4'd8,  4'd13},
      '{4'd3, 4'd4, 4'd9,  4'd14}
   };

   function automatic bit rounds_legal(input int r);
      return (r >= 2) && ((r % 2) == 0);
   endfunction

   function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
      return (v << n) | (v >> (32 - n));
   endfunction

endpackage

// File: rtl/chacha_block_gen_qr.sv
// Combinational ChaCha quarter-round on four 32-bit words.
module chacha_qr
   import chacha_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] c_i,
   input  logic [31:0] d_i,
   output logic [31:0] a_o,
   output logic [31:0] b_o,
   output logic [31:0] c_o,
   output logic [31:0] d_o
);

   logic [31:0] a1, b1, c1, d1;

   assign a1  = a_i + b_i;
   assign d1  = rotl32(d_i ^ a1, 16);
   assign c1  = c_i + d1;
   assign b1  = rotl32(b_i ^ c1, 12);
   assign a_o = a1 + b1;
   assign d_o = rotl32(d1 ^ a_o, 8);
   assign c_o = c1 + d_o;
   assign b_o = rotl32(b1 ^ c_o, 7);

endmodule

// File: rtl/chacha_block_gen.sv
// Iterative ChaCha keystream block generator: one column or diagonal round per cycle,
// result held under backpressure, 64-bit block counter auto-advances between requests.
module chacha_block_gen
   import chacha_pkg::*;
#(
   parameter int           ROUNDS = 20,
   parameter logic [127:0] CONST  = CHACHA_CONST_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] key,
   input  logic [63:0]  nonce,
   input  logic [63:0]  ctr_init,
   input  logic         ctr_load,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [511:0] block,
   output logic [63:0]  ctr,
   output logic         ctr_wrap
);

   localparam int RW = $clog2(ROUNDS + 1);

   if (!rounds_legal(ROUNDS)) begin : g_rounds_illegal
      $error("chacha_block_gen: ROUNDS must be even and >= 2");
   end

   state_e          state_q, state_d;
   logic [RW-1:0]   rcnt_q, rcnt_d;
   state_t          x_q, x_d, init_q, init_d;
   state_t          x_col, x_diag, load_x;
   logic [511:0]    block_q, block_d, blk_sum;
   logic [63:0]     ctr_q, ctr_d, ctr_next, start_ctr;
   logic            ctr_wrap_q, ctr_wrap_d;
   logic            out_valid_q, out_valid_d;
   logic            accept;

   logic [3:0][3:0][31:0] qr_in, qr_out;

   // Operand routing: rcnt parity selects column vs diagonal sets; results go back in place.
   for (genvar q = 0; q < 4; q++) begin : g_qr
      for (genvar j = 0; j < 4; j++) begin : g_op
         assign qr_in[q][j]            = rcnt_q[0] ? x_q[DIAG_IDX[q][j]] : x_q[COL_IDX[q][j]];
         assign x_col[COL_IDX[q][j]]   = qr_out[q][j];
         assign x_diag[DIAG_IDX[q][j]] = qr_out[q][j];
      end
      chacha_qr u_qr (
         .a_i (qr_in[q][0]),
         .b_i (qr_in[q][1]),
         .c_i (qr_in[q][2]),
         .d_i (qr_in[q][3]),
         .a_o (qr_out[q][0]),
         .b_o (qr_out[q][1]),
         .c_o (qr_out[q][2]),
         .d_o (qr_out[q][3])
      );
   end

   assign start_ctr = ctr_load ? ctr_init : ctr_q;
   assign ctr_next  = {init_q[13], init_q[12]} + 64'd1;

   for (genvar i = 0; i < 4; i++) begin : g_ld_const
      assign load_x[i] = CONST[32*i +: 32];
   end
   for (genvar i = 0; i < 8; i++) begin : g_ld_key
      assign load_x[4+i] = key[32*i +: 32];
   end
   assign load_x[12] = start_ctr[31:0];
   assign load_x[13] = start_ctr[63:32];
   assign load_x[14] = nonce[31:0];
   assign load_x[15] = nonce[63:32];

   for (genvar i = 0; i < 16; i++) begin : g_sum
      assign blk_sum[32*i +: 32] = x_q[i] + init_q[i];
   end

   assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      rcnt_d      = rcnt_q;
      x_d         = x_q;
      init_d      = init_q;
      block_d     = block_q;
      ctr_d       = ctr_q;
      ctr_wrap_d  = 1'b0;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: ;
         ST_ROUND: begin
            x_d    = rcnt_q[0] ? x_diag : x_col;
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_q == RW'(ROUNDS - 1)) state_d = ST_FINAL;
         end
         ST_FINAL: begin
            block_d     = blk_sum;
            out_valid_d = 1'b1;
            ctr_d       = ctr_next;
            ctr_wrap_d  = (ctr_next == 64'd0);
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Accept overrides the HOLD->IDLE drain so a consume and a new request share one edge.
      if (accept) begin
         x_d     = load_x;
         init_d  = load_x;
         rcnt_d  = '0;
         state_d = ST_ROUND;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rcnt_q      <= '0;
         x_q         <= '0;
         init_q      <= '0;
         block_q     <= '0;
         ctr_q       <= '0;
         ctr_wrap_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rcnt_q      <= rcnt_d;
         x_q         <= x_d;
         init_q      <= init_d;
         block_q     <= block_d;
         ctr_q       <= ctr_d;
         ctr_wrap_q  <= ctr_wrap_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign block     = block_q;
   assign ctr       = ctr_q;
   assign ctr_wrap  = ctr_wrap_q;

endmodule
